// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcode encodings and legality helper shared by alu_pipe_gen and alu_pipe_exec
package alu_pipe_pkg;
  typedef logic [3:0] func_t;
  localparam func_t OP_ADD = 4'd0;
  localparam func_t OP_SUB = 4'd1;
  localparam func_t OP_MUL = 4'd2;
  localparam func_t OP_AND = 4'd3;
  localparam func_t OP_OR  = 4'd4;
  localparam func_t OP_XOR = 4'd5;
  localparam func_t OP_A   = 4'd6;
  localparam func_t OP_B   = 4'd7;
  localparam func_t OP_IMM = 4'd8;
  localparam func_t OP_LAST_LEGAL = OP_IMM;
  function automatic logic is_legal(input func_t f);
    return f <= OP_LAST_LEGAL;
  endfunction
endpackage

// File: rtl/alu_pipe_exec.sv
// alu_pipe_exec: combinational ALU; all results wrap modulo 2**DW, illegal opcodes yield 0
module alu_pipe_exec
  import alu_pipe_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  input  func_t         func,
  output logic [DW-1:0] z,
  output logic          illegal
);
  always_comb begin
    illegal = !is_legal(func);
    case (func)
      OP_ADD:  z = a + b;
      OP_SUB:  z = a - b;
      OP_MUL:  z = a * b;
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_XOR:  z = a ^ b;
      OP_A:    z = a;
      OP_B:    z = b;
      OP_IMM:  z = imm;
      default: z = '0;
    endcase
  end
endmodule

// File: rtl/alu_pipe_gen.sv
// alu_pipe_gen: operand read -> execute -> regbank writeback -> memory store pipeline.
// ALU_FWD_EN: bypass operands from S2/S3 with no issue stall; otherwise RAW hazards stall issue.
module alu_pipe_gen
  import alu_pipe_pkg::*;
#(
  parameter  int DW   = 16,
  parameter  int NREG = 16,
  parameter  int AW   = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [RW-1:0] rd,
  input  func_t         func,
  input  logic [DW-1:0] imm,
  input  logic [AW-1:0] addr,
  output logic          out_valid,
  output logic [DW-1:0] out_z,
  output logic          out_err,
  input  logic [AW-1:0] mem_raddr,
  output logic [DW-1:0] mem_rdata
);
  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    func_t         func;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } stage_t;

  stage_t        s1_d, s1_q;
  logic [DW-1:0] regbank_q [NREG];
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] a_q, b_q, op_a, op_b, ex_z, s2_z_q, s3_z_q;
  logic [RW-1:0] s2_rd_q;
  logic [AW-1:0] s2_addr_q, s3_addr_q;
  logic          accept, ex_illegal, s2_valid_q, s2_err_q, s2_we, s3_we_q;

  assign accept = in_valid && in_ready;
  assign s2_we  = s2_valid_q && !s2_err_q;
  assign s1_d   = '{valid: accept, rd: rd, func: func, addr: addr, data: imm};

`ifdef ALU_FWD_EN
  logic [RW-1:0] rs1_q, rs2_q, s3_rd_q;
  assign in_ready = !rst;
  // youngest producer wins: S2 result first, then the data S3 just wrote back
  assign op_a = (s2_we && s2_rd_q == rs1_q) ? s2_z_q : (s3_we_q && s3_rd_q == rs1_q) ? s3_z_q : a_q;
  assign op_b = (s2_we && s2_rd_q == rs2_q) ? s2_z_q : (s3_we_q && s3_rd_q == rs2_q) ? s3_z_q : b_q;
  always_ff @(posedge clk) begin
    rs1_q   <= rs1;
    rs2_q   <= rs2;
    s3_rd_q <= s2_rd_q;
  end
`else
  // hold issue until any in-flight writer of rs1/rs2 has reached the regbank
  assign in_ready = !rst
                 && !(s1_q.valid && (s1_q.rd == rs1 || s1_q.rd == rs2))
                 && !(s2_valid_q && (s2_rd_q == rs1 || s2_rd_q == rs2));
  assign op_a = a_q;
  assign op_b = b_q;
`endif

  alu_pipe_exec #(.DW(DW)) u_exec (
    .a       (op_a),
    .b       (op_b),
    .imm     (s1_q.data),
    .func    (s1_q.func),
    .z       (ex_z),
    .illegal (ex_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_err_q   <= 1'b0;
      s3_we_q    <= 1'b0;
      out_valid  <= 1'b0;
      out_z      <= '0;
      out_err    <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_valid_q <= s1_q.valid;
      s2_err_q   <= ex_illegal;
      s3_we_q    <= s2_we;
      out_valid  <= s2_valid_q;
      out_err    <= s2_valid_q && s2_err_q;
      if (s2_valid_q) out_z <= s2_z_q;
    end
    a_q       <= regbank_q[rs1];
    b_q       <= regbank_q[rs2];
    s2_rd_q   <= s1_q.rd;
    s2_addr_q <= s1_q.addr;
    s2_z_q    <= ex_z;
    s3_addr_q <= s2_addr_q;
    s3_z_q    <= s2_z_q;
  end

  always_ff @(posedge clk) begin
    if (rst) regbank_q <= '{default: '0};
    else if (s2_we) regbank_q[s2_rd_q] <= s2_z_q;
  end

  always_ff @(posedge clk) begin
    if (!rst && s3_we_q) mem_q[s3_addr_q] <= s3_z_q;
    mem_rdata <= rst ? '0 : mem_q[mem_raddr];
  end
endmodule

// File: tb/tb_alu_pipe_gen.sv
// tb_alu_pipe_gen: vector table plus hand-written corner sequences, scored through an output queue
module tb_alu_pipe_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  rs1 = '0, rs2 = '0, rd = '0, func = '0;
  logic [15:0] imm = '0;
  logic [7:0]  addr = '0;
  logic        out_valid, out_err;
  logic [15:0] out_z, mem_rdata;
  logic [7:0]  mem_raddr = '0;

  always #5 clk = ~clk;

  alu_pipe_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .imm(imm), .addr(addr),
    .out_valid(out_valid), .out_z(out_z), .out_err(out_err),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [3:0]  rs1, rs2, rd, func;
    logic [15:0] imm;
    logic [7:0]  addr;
    logic [15:0] z;
    logic        err;
  } vec_t;

  vec_t        tbl [20];
  logic [16:0] sb [$];
  int          checks = 0, errors = 0, nout = 0;

  function automatic vec_t mk(input logic [3:0] s1, s2, d, f, input logic [15:0] im,
                              input logic [7:0] ad, input logic [15:0] z, input logic err);
    vec_t v;
    v.rs1 = s1; v.rs2 = s2; v.rd = d; v.func = f; v.imm = im; v.addr = ad; v.z = z; v.err = err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input vec_t v, output int st);
    @(negedge clk);
    rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; func = v.func; imm = v.imm; addr = v.addr;
    in_valid = 1'b1;
    st = 0;
    #1;
    while (!in_ready && st < 20) begin
      @(negedge clk);
      #1;
      st++;
    end
    if (!in_ready) check("in_ready timeout", in_ready, 1);
    else sb.push_back({v.err, v.z});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic mem_chk(input logic [7:0] a, input logic [15:0] e);
    @(negedge clk);
    mem_raddr = a;
    @(posedge clk);
    #1 check($sformatf("mem[%0h]", a), mem_rdata, e);
  endtask

  always @(posedge clk) begin
    logic [16:0] e;
    #1;
    if (out_valid) begin
      if (sb.size() == 0) check("unexpected out_valid", out_valid, 0);
      else begin
        e = sb.pop_front();
        check($sformatf("out_z#%0d", nout), out_z, e[15:0]);
        check($sformatf("out_err#%0d", nout), out_err, e[16]);
        nout++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    tbl[0]  = mk(0, 0, 1, 8, 16'h0005, 8'h40, 16'h0005, 0);
    tbl[1]  = mk(0, 0, 2, 8, 16'h0003, 8'h41, 16'h0003, 0);
    tbl[2]  = mk(1, 2, 3, 0, 16'h0000, 8'h10, 16'h0008, 0);
    tbl[3]  = mk(1, 2, 7, 3, 16'h0000, 8'h60, 16'h0001, 0);
    tbl[4]  = mk(1, 2, 8, 4, 16'h0000, 8'h44, 16'h0007, 0);
    tbl[5]  = mk(1, 2, 9, 5, 16'h0000, 8'h20, 16'h0006, 0);
    tbl[6]  = mk(3, 0, 10, 6, 16'h0000, 8'h46, 16'h0008, 0);
    tbl[7]  = mk(0, 2, 11, 7, 16'h0000, 8'h47, 16'h0003, 0);
    tbl[8]  = mk(1, 3, 12, 2, 16'h0000, 8'h48, 16'h0028, 0);
    tbl[9]  = mk(0, 0, 1, 8, 16'hFFFF, 8'h49, 16'hFFFF, 0);
    tbl[10] = mk(0, 0, 2, 8, 16'h0001, 8'h4A, 16'h0001, 0);
    tbl[11] = mk(1, 2, 13, 0, 16'h0000, 8'h4B, 16'h0000, 0);
    tbl[12] = mk(0, 2, 14, 1, 16'h0000, 8'h4C, 16'hFFFF, 0);
    tbl[13] = mk(0, 0, 15, 8, 16'h0100, 8'h4D, 16'h0100, 0);
    tbl[14] = mk(15, 15, 13, 2, 16'h0000, 8'h4E, 16'h0000, 0);
    tbl[15] = mk(0, 0, 1, 12, 16'h0BAD, 8'h20, 16'h0000, 1);
    tbl[16] = mk(1, 0, 14, 6, 16'h0000, 8'h4F, 16'hFFFF, 0);
    tbl[17] = mk(0, 0, 9, 8, 16'h1234, 8'h50, 16'h1234, 0);
    tbl[18] = mk(0, 0, 9, 8, 16'h5678, 8'h51, 16'h5678, 0);
    tbl[19] = mk(9, 0, 10, 6, 16'h0000, 8'h52, 16'h5678, 0);

    repeat (3) @(negedge clk);
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_z", out_z, 0);
    check("rst out_err", out_err, 0);
    check("rst mem_rdata", mem_rdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) issue(tbl[i], st);
    drain();
    mem_chk(8'h10, 16'h0008);
    mem_chk(8'h20, 16'h0006);
    mem_chk(8'h4E, 16'h0000);
    mem_chk(8'h51, 16'h5678);

    issue(mk(0, 0, 2, 8, 16'h0003, 8'h53, 16'h0003, 0), st);
    drain();
    issue(mk(3, 2, 4, 1, 16'h0000, 8'h54, 16'h0005, 0), st);
    check("chain producer stall", st, 0);
    issue(mk(4, 4, 5, 2, 16'h0000, 8'h55, 16'h0019, 0), st);
    check("chain dependent stall is 0 or 2", (st == 0 || st == 2), 1);
    drain();

    issue(mk(0, 0, 6, 8, 16'h00AA, 8'h60, 16'h00AA, 0), st);
    rst = 1'b1;
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      check("in_ready during rst", in_ready, 0);
      check("out_valid during rst", out_valid, 0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("out_valid after rst", out_valid, 0);
    end
    issue(mk(6, 0, 7, 6, 16'h0000, 8'h61, 16'h0000, 0), st);
    issue(mk(1, 0, 8, 6, 16'h0000, 8'h62, 16'h0000, 0), st);
    drain();
    mem_chk(8'h60, 16'h0001);

    issue(mk(0, 0, 11, 8, 16'h1111, 8'h30, 16'h1111, 0), st);
    drain();
    issue(mk(0, 0, 11, 8, 16'h2222, 8'h30, 16'h2222, 0), st);
    mem_raddr = 8'h30;
    repeat (3) @(posedge clk);
    #1 check("same-cycle read old", mem_rdata, 16'h1111);
    @(posedge clk);
    #1 check("same-cycle read new", mem_rdata, 16'h2222);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
